an_encoder_seq: RTL and testbench

AN_ENCODER_SEQ -- requirements
Module: an_encoder_seq

---
 rtl/an_encoder_seq.sv | 125 ++++++++++++
 tb/tb_an_encoder_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/an_encoder_seq.sv
// an_encoder_seq: sequential AN-code encoder with optional error injection.
//
// Computes code_out = A*N with a shift-and-add multiplier. Each cycle in MUL
// handles one bit of the constant A, so a word takes A_W iterations. When the
// product is finished, an arithmetic error of +/-2^k can be folded in, which
// lets a downstream AN decoder be exercised with known faults.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active high
//   in_valid   n_in and injection controls are valid
//   in_ready   encoder is idle and can accept a word
//   n_in       data word N
//   inj_en     apply an arithmetic error to this word
//   inj_sign   0: add 2^k, 1: subtract 2^k
//   inj_bit    error position k (ignored when k >= C_W)
//   out_valid  code_out holds a finished codeword
//   out_ready  downstream accepts code_out
//   code_out   (A*N +/- error) mod 2^C_W, held after handshake
//   busy       encoder is not idle
module an_encoder_seq #(
    parameter int A   = 47,
    parameter int A_W = 6,
    parameter int N_W = 17,
    parameter int C_W = 23
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N_W-1:0] n_in,
    input  logic           inj_en,
    input  logic           inj_sign,
    input  logic [4:0]     inj_bit,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [C_W-1:0] code_out,
    output logic           busy
);

    localparam int             I_W    = (A_W > 1) ? $clog2(A_W) : 1;
    localparam logic [A_W-1:0] A_BITS = A_W'(A);
    localparam logic [I_W-1:0] I_LAST = I_W'(A_W - 1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t         state;
    logic [N_W-1:0] n_q;
    logic           inj_en_q;
    logic           inj_sign_q;
    logic [4:0]     inj_bit_q;
    logic [C_W-1:0] acc;
    logic [I_W-1:0] i;

    logic [C_W-1:0] partial;
    logic [C_W-1:0] acc_nxt;
    logic [C_W-1:0] err;
    logic [C_W-1:0] code_nxt;

    // One multiplier step, plus the injected error applied to the value the
    // final step produces. Subtraction wraps modulo 2^C_W.
    always_comb begin
        partial  = A_BITS[i] ? (C_W'(n_q) << i) : '0;
        acc_nxt  = acc + partial;
        err      = '0;
        if (inj_en_q && (int'(inj_bit_q) < C_W))
            err = C_W'(1) << inj_bit_q;
        code_nxt = inj_sign_q ? (acc_nxt - err) : (acc_nxt + err);
    end

    assign busy = ~in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            code_out   <= '0;
            acc        <= '0;
            i          <= '0;
            n_q        <= '0;
            inj_en_q   <= 1'b0;
            inj_sign_q <= 1'b0;
            inj_bit_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        n_q        <= n_in;
                        inj_en_q   <= inj_en;
                        inj_sign_q <= inj_sign;
                        inj_bit_q  <= inj_bit;
                        acc        <= '0;
                        i          <= '0;
                        in_ready   <= 1'b0;
                        state      <= MUL;
                    end
                end
                MUL: begin
                    acc <= acc_nxt;
                    i   <= i + 1'b1;
                    if (i == I_LAST) begin
                        code_out  <= code_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Returning to IDLE here means the earliest next accept
                    // is one edge later, so no accept overlaps this handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_an_encoder_seq.sv
// Self-checking bench for an_encoder_seq. Expected codewords come from a
// plain arithmetic model: (A*N +/- 2^k) mod 2^C_W.
module tb_an_encoder_seq;

    localparam int A   = 47;
    localparam int A_W = 6;
    localparam int N_W = 17;
    localparam int C_W = 23;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N_W-1:0] n_in;
    logic           inj_en;
    logic           inj_sign;
    logic [4:0]     inj_bit;
    logic           out_valid;
    logic           out_ready;
    logic [C_W-1:0] code_out;
    logic           busy;

    int pass_cnt = 0;
    int total    = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    an_encoder_seq #(.A(A), .A_W(A_W), .N_W(N_W), .C_W(C_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .n_in(n_in), .inj_en(inj_en), .inj_sign(inj_sign), .inj_bit(inj_bit),
        .out_valid(out_valid), .out_ready(out_ready), .code_out(code_out),
        .busy(busy)
    );

    function automatic logic [C_W-1:0] ref_code(input longint n, input bit en,
                                                input bit sgn, input int k);
        longint v;
        v = longint'(A) * n;
        if (en && k < C_W)
            v = sgn ? v - (longint'(1) << k) : v + (longint'(1) << k);
        return C_W'(v & ((longint'(1) << C_W) - 1));
    endfunction

    // Accepts one word and waits for out_valid; lat is the number of rising
    // edges after the accept edge. Inputs are scrambled while the word is busy.
    task automatic do_word(input logic [N_W-1:0] n, input bit en, input bit sgn,
                           input logic [4:0] k, output int lat);
        @(negedge clk);
        in_valid = 1'b1; n_in = n; inj_en = en; inj_sign = sgn; inj_bit = k;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            n_in = N_W'($urandom); inj_en = 1'($urandom);
            inj_sign = 1'($urandom); inj_bit = 5'($urandom);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic finish_word();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        n_in = '0; inj_en = 1'b0; inj_sign = 1'b0; inj_bit = '0;
        #2;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
        total++; if (code_out !== '0) $display("FAIL reset_code: got %0d expected 0", code_out); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        int lat;
        do_word(17'd1343, 1'b0, 1'b0, 5'd0, lat);
        total++; if (lat !== 6) $display("FAIL nominal_latency: got %0d expected 6", lat); else pass_cnt++;
        total++; if (code_out !== 23'd63121) $display("FAIL nominal_code: got %0d expected 63121", code_out); else pass_cnt++;
        total++; if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL nominal_busy: got busy=%b in_ready=%b expected 1/0", busy, in_ready); else pass_cnt++;
        finish_word();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL nominal_handshake: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); else pass_cnt++;
        total++; if (code_out !== 23'd63121) $display("FAIL nominal_retain: got %0d expected 63121", code_out); else pass_cnt++;
    endtask

    task automatic test_injection();
        bit          sg[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
        int          kb[4]  = '{0, 22, 15, 16};
        int unsigned exp[4] = '{63122, 4257425, 30353, 8386193};
        int lat;
        for (int t = 0; t < 4; t++) begin
            do_word(17'd1343, 1'b1, sg[t], 5'(kb[t]), lat);
            total++; if (code_out !== C_W'(exp[t])) $display("FAIL inject_%0d: got %0d expected %0d", t, code_out, exp[t]); else pass_cnt++;
            finish_word();
        end
    endtask

    task automatic test_boundaries();
        int lat;
        do_word(17'd0, 1'b0, 1'b0, 5'd0, lat);
        total++; if (code_out !== 23'd0) $display("FAIL bound_zero: got %0d expected 0", code_out); else pass_cnt++;
        finish_word();
        do_word(17'd131071, 1'b0, 1'b0, 5'd0, lat);
        total++; if (code_out !== 23'd6160337) $display("FAIL bound_max: got %0d expected 6160337", code_out); else pass_cnt++;
        finish_word();
        do_word(17'd1343, 1'b1, 1'b0, 5'd23, lat);
        total++; if (code_out !== 23'd63121) $display("FAIL bound_bit23: got %0d expected 63121", code_out); else pass_cnt++;
        finish_word();
        do_word(17'd1343, 1'b1, 1'b1, 5'd31, lat);
        total++; if (code_out !== 23'd63121) $display("FAIL bound_bit31: got %0d expected 63121", code_out); else pass_cnt++;
        finish_word();
    endtask

    task automatic test_random();
        logic [N_W-1:0] n;
        bit en, sg;
        logic [4:0] k;
        logic [C_W-1:0] exp;
        int lat;
        for (int t = 0; t < 25; t++) begin
            n = N_W'($urandom); en = 1'($urandom); sg = 1'($urandom); k = 5'($urandom);
            exp = ref_code(longint'(n), en, sg, int'(k));
            do_word(n, en, sg, k, lat);
            total++; if (lat !== 6 || code_out !== exp) $display("FAIL random_%0d: got code %0d lat %0d expected code %0d lat 6", t, code_out, lat, exp); else pass_cnt++;
            finish_word();
        end
    endtask

    task automatic test_backpressure();
        logic [N_W-1:0] n;
        logic [C_W-1:0] exp;
        int lat;
        n = N_W'($urandom);
        exp = ref_code(longint'(n), 1'b0, 1'b0, 0);
        do_word(n, 1'b0, 1'b0, 5'd0, lat);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; n_in = N_W'($urandom);
            @(posedge clk);
            @(negedge clk);
            total++; if (out_valid !== 1'b1 || code_out !== exp || in_ready !== 1'b0) $display("FAIL backpressure_%0d: got valid=%b code=%0d in_ready=%b expected 1/%0d/0", c, out_valid, code_out, in_ready, exp); else pass_cnt++;
        end
        in_valid = 1'b0;
        finish_word();
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || code_out !== exp) $display("FAIL backpressure_idle: got in_ready=%b code=%0d expected 1/%0d", in_ready, code_out, exp); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int lat;
        @(negedge clk);
        in_valid = 1'b1; n_in = 17'd1343; inj_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || code_out !== '0) $display("FAIL midreset_state: got in_ready=%b busy=%b valid=%b code=%0d expected 1/0/0/0", in_ready, busy, out_valid, code_out); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total++; if (seen !== 0) $display("FAIL midreset_no_valid: got %0d pulses expected 0", seen); else pass_cnt++;
        do_word(17'd2, 1'b0, 1'b0, 5'd0, lat);
        total++; if (lat !== 6 || code_out !== 23'd94) $display("FAIL midreset_next: got code %0d lat %0d expected 94 lat 6", code_out, lat); else pass_cnt++;
        finish_word();
    endtask

    task automatic test_back_to_back();
        logic [N_W-1:0] w[4];
        logic [C_W-1:0] exp[4];
        int acc_cyc[4];
        int idx = 0;
        int nout = 0;
        for (int t = 0; t < 4; t++) begin
            w[t] = N_W'($urandom);
            exp[t] = ref_code(longint'(w[t]), 1'b0, 1'b0, 0);
        end
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1; inj_en = 1'b0;
        for (int c = 0; c < 80 && nout < 4; c++) begin
            if (out_valid) begin
                total++; if (code_out !== exp[nout]) $display("FAIL b2b_code_%0d: got %0d expected %0d", nout, code_out, exp[nout]); else pass_cnt++;
                nout++;
            end
            if (in_ready && idx < 4) begin
                n_in = w[idx]; acc_cyc[idx] = cyc; idx++;
            end else begin
                n_in = N_W'($urandom);
                if (idx == 4) in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        total++; if (nout !== 4) $display("FAIL b2b_count: got %0d words expected 4", nout); else pass_cnt++;
        for (int t = 1; t < 4; t++) begin
            total++; if (acc_cyc[t] - acc_cyc[t-1] !== 8) $display("FAIL b2b_spacing_%0d: got %0d expected 8", t, acc_cyc[t] - acc_cyc[t-1]); else pass_cnt++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_injection();
        test_boundaries();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
